// File: rtl/freq_div_ctrl_if.sv
// Ratio-request bundle for freq_div_ctrl: two valid/ready requesters carrying divide ratios.
interface freq_div_ctrl_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic             req0_valid;
  logic [WIDTH-1:0] req0_div;
  logic             req0_ready;
  logic             req1_valid;
  logic [WIDTH-1:0] req1_div;
  logic             req1_ready;

  modport master (
    output req0_valid, req0_div, req1_valid, req1_div,
    input  req0_ready, req1_ready
  );

  modport slave (
    input  req0_valid, req0_div, req1_valid, req1_div,
    output req0_ready, req1_ready
  );
endinterface

// File: rtl/freq_div_ctrl.sv
// Integer clock-divider controller: divide counter, run/drain FSM, round-robin ratio arbiter.
// Optional feature macro FREQ_DIV_CTRL_ERR_EN: reject ratios <2 with an err pulse instead of clamping.
module freq_div_ctrl #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned DEFAULT_DIV = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  freq_div_ctrl_if.slave   req,
  output logic             out,
  output logic             tick,
  output logic             busy,
  output logic [WIDTH-1:0] cur_div,
  output logic             err
);

  localparam int unsigned WP1 = WIDTH + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_cur_div;
  logic [WIDTH-1:0] r_shadow;
  logic             r_pend;
  logic             r_ptr;
  logic             r_out;
  logic             r_tick;
  logic             r_busy;
  logic             r_err;

  state_t           w_state_nxt;
  logic [WIDTH-1:0] w_cnt_nxt;
  logic [WIDTH-1:0] w_cur_div_nxt;
  logic [WIDTH-1:0] w_shadow_nxt;
  logic             w_pend_nxt;
  logic             w_ptr_nxt;
  logic             w_err_nxt;
  logic             w_bound;
  logic [WIDTH-1:0] w_cnt_step;
  logic             w_grant0;
  logic             w_grant1;
  logic             w_ready0;
  logic             w_ready1;
  logic             w_acc0;
  logic             w_acc1;
  logic             w_acc;
  logic [WIDTH-1:0] w_div_sel;
  logic [WIDTH:0]   w_half;
  logic             w_out_nxt;
  logic             w_tick_nxt;

  // Pointer names the favoured requester; the other only wins when the favoured one is idle.
  assign w_grant0 = (r_ptr == 1'b0) || !req.req1_valid;
  assign w_grant1 = (r_ptr == 1'b1) || !req.req0_valid;
  assign w_ready0 = rst && !r_pend && w_grant0;
  assign w_ready1 = rst && !r_pend && w_grant1;
  assign req.req0_ready = w_ready0;
  assign req.req1_ready = w_ready1;

  assign w_acc0    = req.req0_valid && w_ready0;
  assign w_acc1    = req.req1_valid && w_ready1;
  assign w_acc     = w_acc0 || w_acc1;
  assign w_div_sel = w_acc1 ? req.req1_div : req.req0_div;

  assign w_bound    = (r_state != ST_IDLE) && (r_cnt == r_cur_div - WIDTH'(1));
  assign w_cnt_step = w_bound ? '0 : r_cnt + WIDTH'(1);

  // Next-state, counter, ratio and shadow update.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_cur_div_nxt = r_cur_div;
    w_shadow_nxt  = r_shadow;
    w_pend_nxt    = r_pend;
    w_ptr_nxt     = r_ptr;
    w_err_nxt     = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = '0;
        if (r_pend) begin
          w_cur_div_nxt = r_shadow;
          w_pend_nxt    = 1'b0;
        end
        if (en) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        w_cnt_nxt = w_cnt_step;
        if (!en) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        w_cnt_nxt = w_cnt_step;
        if (en)           w_state_nxt = ST_RUN;
        else if (w_bound) w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase

    // A pending ratio only takes effect on a period boundary while counting.
    if (w_bound && r_pend) begin
      w_cur_div_nxt = r_shadow;
      w_cnt_nxt     = '0;
      w_pend_nxt    = 1'b0;
    end

    // Accepts only happen with r_pend clear, so they never collide with the apply above.
    if (w_acc) begin
      w_ptr_nxt = !w_acc1;
`ifdef FREQ_DIV_CTRL_ERR_EN
      if (w_div_sel < WIDTH'(2)) begin
        w_err_nxt = 1'b1;
      end else begin
        w_shadow_nxt = w_div_sel;
        w_pend_nxt   = 1'b1;
      end
`else
      w_shadow_nxt = (w_div_sel < WIDTH'(2)) ? WIDTH'(2) : w_div_sel;
      w_pend_nxt   = 1'b1;
`endif
    end
  end

  // Outputs are registered from next-state values so they align with the counter.
  assign w_half     = ({1'b0, w_cur_div_nxt} + WP1'(1)) >> 1;
  assign w_out_nxt  = (w_state_nxt != ST_IDLE) && ({1'b0, w_cnt_nxt} < w_half);
  assign w_tick_nxt = (w_state_nxt != ST_IDLE) && (w_cnt_nxt == w_cur_div_nxt - WIDTH'(1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_cur_div <= WIDTH'(DEFAULT_DIV);
      r_shadow  <= WIDTH'(DEFAULT_DIV);
      r_pend    <= 1'b0;
      r_ptr     <= 1'b0;
      r_out     <= 1'b0;
      r_tick    <= 1'b0;
      r_busy    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_cur_div <= w_cur_div_nxt;
      r_shadow  <= w_shadow_nxt;
      r_pend    <= w_pend_nxt;
      r_ptr     <= w_ptr_nxt;
      r_out     <= w_out_nxt;
      r_tick    <= w_tick_nxt;
      r_busy    <= (w_state_nxt != ST_IDLE);
      r_err     <= w_err_nxt;
    end
  end

  assign out     = r_out;
  assign tick    = r_tick;
  assign busy    = r_busy;
  assign cur_div = r_cur_div;
  assign err     = r_err;

endmodule

// File: tb/tb_freq_div_ctrl.sv
// Directed bench for freq_div_ctrl: run, ratio changes, arbitration, drain, reset, low ratio.
module tb_freq_div_ctrl;

  logic       clk;
  logic       rst;
  logic       en;
  logic       d_out;
  logic       d_tick;
  logic       d_busy;
  logic [7:0] d_cur_div;
  logic       d_err;

  int n_vec;
  int n_err;

`ifdef FREQ_DIV_CTRL_ERR_EN
  localparam int   LOW_DIV = 5;
  localparam logic LOW_ERR = 1'b1;
`else
  localparam int   LOW_DIV = 2;
  localparam logic LOW_ERR = 1'b0;
`endif

  freq_div_ctrl_if #(.WIDTH(8)) u_if ();

  freq_div_ctrl #(.WIDTH(8), .DEFAULT_DIV(5)) u_dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .req     (u_if),
    .out     (d_out),
    .tick    (d_tick),
    .busy    (d_busy),
    .cur_div (d_cur_div),
    .err     (d_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Checks n consecutive running cycles starting at counter value cnt0 with ratio div.
  task automatic run_chk(input string tag, input int div, input int cnt0, input int n);
    int c;
    c = cnt0;
    for (int k = 0; k < n; k++) begin
      chk1({tag, "_out"},  d_out,  (c < (div + 1) / 2));
      chk1({tag, "_tick"}, d_tick, (c == div - 1));
      chk1({tag, "_busy"}, d_busy, 1'b1);
      chk8({tag, "_div"},  d_cur_div, 8'(div));
      @(negedge clk);
      c = (c + 1) % div;
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b0;
    en  = 1'b0;
    u_if.req0_valid = 1'b0;
    u_if.req0_div   = 8'd0;
    u_if.req1_valid = 1'b0;
    u_if.req1_div   = 8'd0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    u_if.req0_valid = 1'b1;
    #1;
    chk1("rst_out",   d_out,  1'b0);
    chk1("rst_tick",  d_tick, 1'b0);
    chk1("rst_busy",  d_busy, 1'b0);
    chk1("rst_err",   d_err,  1'b0);
    chk8("rst_div",   d_cur_div, 8'd5);
    chk1("rst_rdy0",  u_if.req0_ready, 1'b0);
    u_if.req0_valid = 1'b0;

    // Basic run at div 5
    @(negedge clk);
    rst = 1'b1;
    en  = 1'b1;
    @(negedge clk);
    run_chk("basic", 5, 0, 10);

    // Accept div 3 in the boundary cycle: one more full period of 5 first
    run_chk("bnd_pre", 5, 0, 4);
    u_if.req0_valid = 1'b1;
    u_if.req0_div   = 8'd3;
    #1;
    chk1("bnd_rdy0", u_if.req0_ready, 1'b1);
    run_chk("bnd_acc", 5, 4, 1);
    u_if.req0_valid = 1'b0;
    #1;
    chk1("bnd_pend_rdy0", u_if.req0_ready, 1'b0);
    run_chk("bnd_old", 5, 0, 5);
    run_chk("bnd_new", 3, 0, 6);

    // Mid-period change to 4 from requester 1 (pointer now favours it)
    run_chk("mid_pre", 3, 0, 1);
    u_if.req1_valid = 1'b1;
    u_if.req1_div   = 8'd4;
    #1;
    chk1("mid_rdy1", u_if.req1_ready, 1'b1);
    run_chk("mid_acc", 3, 1, 1);
    u_if.req1_valid = 1'b0;
    run_chk("mid_old", 3, 2, 1);
    run_chk("mid_new", 4, 0, 8);

    // Arbitration: both valid, pointer favours req0
    u_if.req0_valid = 1'b1;
    u_if.req0_div   = 8'd6;
    u_if.req1_valid = 1'b1;
    u_if.req1_div   = 8'd7;
    #1;
    chk1("arb_rdy0", u_if.req0_ready, 1'b1);
    chk1("arb_rdy1", u_if.req1_ready, 1'b0);
    run_chk("arb_acc", 4, 0, 1);
    u_if.req0_valid = 1'b0;
    #1;
    chk1("arb_pend_rdy0", u_if.req0_ready, 1'b0);
    chk1("arb_pend_rdy1", u_if.req1_ready, 1'b0);
    run_chk("arb_old", 4, 1, 3);
    chk1("arb_rdy1_free", u_if.req1_ready, 1'b1);
    run_chk("arb_six_acc", 6, 0, 1);
    u_if.req1_valid = 1'b0;
    #1;
    chk1("arb_pend2_rdy1", u_if.req1_ready, 1'b0);
    run_chk("arb_six", 6, 1, 5);
    run_chk("arb_seven", 7, 0, 7);

    // Drain: en dropped at cnt 1 finishes the period, then idles
    run_chk("drn_pre", 7, 0, 1);
    en = 1'b0;
    run_chk("drn", 7, 1, 6);
    chk1("drn_idle_out",  d_out,  1'b0);
    chk1("drn_idle_busy", d_busy, 1'b0);
    chk1("drn_idle_tick", d_tick, 1'b0);
    chk8("drn_idle_div",  d_cur_div, 8'd7);

    // Re-enable in DRAIN at cnt 3: period continues without a gap
    en = 1'b1;
    @(negedge clk);
    run_chk("re_run", 7, 0, 2);
    en = 1'b0;
    run_chk("re_stop", 7, 2, 1);
    en = 1'b1;
    run_chk("re_drain", 7, 3, 11);

    // Reset mid-period at cnt 2
    run_chk("rst2_pre", 7, 0, 2);
    rst = 1'b0;
    en  = 1'b0;
    u_if.req1_valid = 1'b1;
    u_if.req1_div   = 8'd9;
    #1;
    chk1("rst2_rdy0_in", u_if.req0_ready, 1'b0);
    chk1("rst2_rdy1_in", u_if.req1_ready, 1'b0);
    @(negedge clk);
    chk1("rst2_out",  d_out,  1'b0);
    chk1("rst2_tick", d_tick, 1'b0);
    chk1("rst2_busy", d_busy, 1'b0);
    chk1("rst2_err",  d_err,  1'b0);
    chk8("rst2_div",  d_cur_div, 8'd5);
    chk1("rst2_rdy1", u_if.req1_ready, 1'b0);
    rst = 1'b1;
    en  = 1'b1;
    u_if.req1_valid = 1'b0;
    @(negedge clk);

    // Low ratio (div 1): dropped with err, or clamped to 2
    u_if.req0_valid = 1'b1;
    u_if.req0_div   = 8'd1;
    #1;
    chk1("low_rdy0", u_if.req0_ready, 1'b1);
    run_chk("low_acc", 5, 0, 1);
    u_if.req0_valid = 1'b0;
    #1;
    chk1("low_err",      d_err, LOW_ERR);
    chk1("low_pend_rdy", u_if.req0_ready, LOW_ERR);
    run_chk("low_c1", 5, 1, 1);
    chk1("low_err_end", d_err, 1'b0);
    run_chk("low_old", 5, 2, 3);
    run_chk("low_new", LOW_DIV, 0, 4);

    en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
